// File: rtl/bist_signature_checker.sv
// BIST response analyser: compacts CUT responses into a Galois MISR while the
// controller's out pulse is high, counts out-pulse rising edges, and on
// bist_end compares both against golden values.
// Ports: clk, reset (sync, active-low), out_pulse, running, bist_end,
//        data_in[WIDTH] -> signature[WIDTH], pulse_cnt[CNT_W], done, pass, fail.
module bist_signature_checker #(
  parameter int unsigned           WIDTH      = 8,
  parameter logic [WIDTH-1:0]      POLY       = 8'h1D,
  parameter logic [WIDTH-1:0]      SEED       = 8'h00,
  parameter logic [WIDTH-1:0]      GOLDEN     = 8'h00,
  parameter int unsigned           EXP_PULSES = 10,
  parameter int unsigned           CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             out_pulse,
  input  logic             running,
  input  logic             bist_end,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {IDLE, CAPTURE, EVAL, RESULT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(EXP_PULSES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_d_q, out_d_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  logic             rise;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] nxt;
  logic [CNT_W-1:0] cnt_inc;

  assign rise    = out_pulse & ~out_d_q;
  // A new run always compacts from SEED, regardless of the held signature.
  assign base    = (state_q == IDLE || state_q == RESULT) ? SEED : sig_q;
  assign nxt     = {base[WIDTH-2:0], 1'b0} ^ (base[WIDTH-1] ? POLY : '0) ^ data_in;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    out_d_d = out_pulse;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE, RESULT: begin
        if (running) begin
          state_d = CAPTURE;
          sig_d   = out_pulse ? nxt : SEED;
          cnt_d   = rise ? CNT_W'(1) : '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      CAPTURE: begin
        // running=1 takes priority, so running && bist_end keeps capturing.
        if (running) begin
          if (out_pulse) sig_d = nxt;
          if (rise)      cnt_d = cnt_inc;
        end else if (bist_end) begin
          state_d = EVAL;
        end else begin
          state_d = IDLE;
        end
      end
      EVAL: begin
        state_d = RESULT;
        done_d  = 1'b1;
        pass_d  = (sig_q == GOLDEN) && (cnt_q == CNT_EXP);
        fail_d  = !((sig_q == GOLDEN) && (cnt_q == CNT_EXP));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      out_d_q <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      out_d_q <= out_d_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign signature = sig_q;
  assign pulse_cnt = cnt_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
module tb_bist_signature_checker;

  localparam logic [7:0] SEED   = 8'h00;
  localparam logic [7:0] GOLDEN = 8'h00;
  localparam int         EXP_P  = 10;

  typedef struct {
    logic [7:0] sig;
    logic [3:0] cnt;
    logic       pas;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       out_pulse;
  logic       running;
  logic       bist_end;
  logic [7:0] data_in;
  logic [7:0] signature;
  logic [3:0] pulse_cnt;
  logic       done, pass, fail;

  int n_err = 0;
  int n_checks = 0;

  exp_t sb[$];

  // reference model state
  logic [7:0] m_sig;
  int         m_cnt;
  logic       m_prev;
  logic       m_active;

  bist_signature_checker #(
    .WIDTH(8), .POLY(8'h1D), .SEED(SEED), .GOLDEN(GOLDEN),
    .EXP_PULSES(EXP_P), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .out_pulse(out_pulse), .running(running),
    .bist_end(bist_end), .data_in(data_in), .signature(signature),
    .pulse_cnt(pulse_cnt), .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] misr(input logic [7:0] b, input logic [7:0] d);
    logic [8:0] t;
    t = {b, 1'b0};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0] ^ d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, advance model, step past the edge
  task automatic cyc(input logic run, input logic op, input logic be, input logic [7:0] d);
    running = run; out_pulse = op; bist_end = be; data_in = d;
    if (run) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_sig = op ? misr(SEED, d) : SEED;
        m_cnt = (op && !m_prev) ? 1 : 0;
      end else begin
        if (op) m_sig = misr(m_sig, d);
        if (op && !m_prev && m_cnt < 15) m_cnt++;
      end
    end
    m_prev = op;
    @(posedge clk); #1;
  endtask

  task automatic bursts(input int n, input int hi, input logic rnd);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < hi; j++) cyc(1'b1, 1'b1, 1'b0, rnd ? 8'($urandom) : 8'h00);
      for (int j = 0; j < 2; j++)  cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic start_run(input string tag);
    cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    check({tag, "_start_done"}, 32'(done), 32'(0));
    check({tag, "_start_pf"}, 32'({pass, fail}), 32'(0));
  endtask

  task automatic finish_run(input string tag);
    exp_t e;
    e.sig = m_sig; e.cnt = 4'(m_cnt);
    e.pas = (m_sig == GOLDEN) && (m_cnt == EXP_P);
    e.name = tag;
    sb.push_back(e);
    m_active = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    check({tag, "_eval_done"}, 32'(done), 32'(0));
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      check({e.name, "_done"}, 32'(done), 32'(1));
      check({e.name, "_sig"}, 32'(signature), 32'(e.sig));
      check({e.name, "_cnt"}, 32'(pulse_cnt), 32'(e.cnt));
      check({e.name, "_pass"}, 32'(pass), 32'(e.pas));
      check({e.name, "_fail"}, 32'(fail), 32'(!e.pas));
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    check({tag, "_hold_done"}, 32'(done), 32'(1));
  endtask

  initial begin
    m_sig = SEED; m_cnt = 0; m_prev = 1'b0; m_active = 1'b0;
    reset = 1'b0; running = 1'b0; out_pulse = 1'b0; bist_end = 1'b0; data_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_sig", 32'(signature), 32'(SEED));
    check("rst_cnt", 32'(pulse_cnt), 32'(0));
    check("rst_flags", 32'({done, pass, fail}), 32'(0));
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // 1: ten clean bursts, golden signature
    start_run("t1");
    bursts(10, 8, 1'b0);
    check("t1_cnt_mid", 32'(pulse_cnt), 32'(10));
    finish_run("t1");

    // 2: two-cycle burst 80,00 -> 1D, one pulse
    start_run("t2");
    cyc(1'b1, 1'b1, 1'b0, 8'h80);
    check("t2_sig_step1", 32'(signature), 32'(8'h80));
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check("t2_sig_model", 32'(signature), 32'(8'h1D));
    finish_run("t2");

    // 3: one burst missing
    start_run("t3");
    bursts(9, 8, 1'b0);
    finish_run("t3");

    // 4: abort mid-run, then full runs
    start_run("t4");
    bursts(3, 4, 1'b1);
    m_active = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    check("t4_abort_done", 32'(done), 32'(0));
    check("t4_abort_pf", 32'({pass, fail}), 32'(0));
    check("t4_abort_sig", 32'(signature), 32'(m_sig));
    check("t4_abort_cnt", 32'(pulse_cnt), 32'(3));
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    check("t4_idle_cnt", 32'(pulse_cnt), 32'(3));
    start_run("t4r");
    bursts(10, 3, 1'b1);
    finish_run("t4r");
    start_run("t4p");
    bursts(10, 8, 1'b0);
    finish_run("t4p");

    // 5: reset during capture
    start_run("t5");
    bursts(4, 3, 1'b1);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 8'h5A);
    check("t5_sig", 32'(signature), 32'(SEED));
    check("t5_cnt", 32'(pulse_cnt), 32'(0));
    check("t5_flags", 32'({done, pass, fail}), 32'(0));
    reset = 1'b1;
    m_active = 1'b0; m_prev = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    check("t5_idle_sig", 32'(signature), 32'(SEED));

    // 6: back-to-back runs from RESULT, then counter saturation
    start_run("t6a");
    bursts(10, 8, 1'b0);
    finish_run("t6a");
    start_run("t6b");
    bursts(10, 8, 1'b0);
    finish_run("t6b");
    start_run("t6s");
    bursts(20, 2, 1'b0);
    check("t6s_sat", 32'(pulse_cnt), 32'(15));
    finish_run("t6s");

    // illegal running && bist_end keeps capturing
    start_run("t7");
    cyc(1'b1, 1'b1, 1'b1, 8'h33);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    check("t7_stay_done", 32'(done), 32'(0));
    check("t7_stay_sig", 32'(signature), 32'(m_sig));
    finish_run("t7");

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
